// File: rtl/kernel_loader.sv
// kernel_loader: streams numRows*D weights into a banked kernel buffer.
// A start in IDLE captures baseAddr/numRows and opens the stream. Each
// accepted beat becomes one buffer write in the following cycle, with banks
// 0..D-1 inside a row and rows ascending from baseAddr (mod 2^A).
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start             begin a load (sampled only in IDLE)
//   baseAddr, numRows first buffer row and row count, captured at start
//   inData, inValid   weight stream beat
//   inReady           loader accepts a beat (high exactly in LOAD)
//   ioInputs          {io_select, write, bank, data}
//   address           kernel-buffer row address of the current write
//   busy, done        not-IDLE flag, one-cycle completion pulse
module kernel_loader #(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7,
    parameter int unsigned D     = (1 << depth),
    parameter int unsigned W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [A-1:0]         baseAddr,
    input  logic [A-1:0]         numRows,
    input  logic [W-1:0]         inData,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [W+depth+1:0]   ioInputs,
    output logic [A-1:0]         address,
    output logic                 busy,
    output logic                 done
);

    localparam logic [depth-1:0] LAST_BANK = depth'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [A-1:0]       r_base;
    logic [A-1:0]       r_rows;
    logic [depth-1:0]   r_bank;
    logic [A-1:0]       r_row;

    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_io_sel;
    logic               r_write;
    logic [depth-1:0]   r_bank_out;
    logic [W-1:0]       r_data;
    logic [A-1:0]       r_addr;

    logic               w_start;
    logic               w_accept;
    logic               w_bank_wrap;
    logic               w_last;

    // Handshake and last-beat detection
    always_comb begin
        w_start     = (r_state == S_IDLE) && start;
        w_accept    = (r_state == S_LOAD) && inValid && r_in_ready;
        w_bank_wrap = (r_bank == LAST_BANK);
        w_last      = w_accept && w_bank_wrap && (r_row == (r_rows - A'(1)));
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (numRows == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture, counters and registered outputs. Status flags are derived
    // from the next state so they line up with r_state in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_base     <= '0;
            r_rows     <= '0;
            r_bank     <= '0;
            r_row      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_io_sel   <= 1'b0;
            r_write    <= 1'b0;
            r_bank_out <= '0;
            r_data     <= '0;
            r_addr     <= '0;
        end else begin
            r_in_ready <= (w_next_state == S_LOAD);
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            r_io_sel   <= (w_next_state != S_IDLE);
            r_write    <= w_accept;

            if (w_start) begin
                r_base <= baseAddr;
                r_rows <= numRows;
                r_bank <= '0;
                r_row  <= '0;
            end

            if (w_accept) begin
                r_data     <= inData;
                r_bank_out <= r_bank;
                r_addr     <= r_base + r_row;
                if (w_bank_wrap) begin
                    r_bank <= '0;
                    r_row  <= r_row + A'(1);
                end else begin
                    r_bank <= r_bank + depth'(1);
                end
            end
        end
    end

    assign inReady  = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign address  = r_addr;
    assign ioInputs = {r_io_sel, r_write, r_bank_out, r_data};

endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 SHALL have parameter depth, default 2, meaning log2 of convolutional-unit size.
REQ-002 SHALL have parameter A, default 7, meaning the kernel-buffer address width.
REQ-003 SHALL have parameter D, default (1<<depth), meaning the number of banks.
REQ-004 SHALL have parameter W, default 16, meaning the weight data width.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: begin a load; sampled only in IDLE.
REQ-008 SHALL have port baseAddr, input, A bits: first buffer row; captured at start.
REQ-009 SHALL have port numRows, input, A bits: rows to load, each row being D weights; captured at start.
REQ-010 SHALL have port inData, input, W bits: the weight stream data.
REQ-011 SHALL have port inValid, input, 1 bit: inData is valid.
REQ-012 SHALL have port inReady, output, 1 bit: the loader accepts a beat.
REQ-013 SHALL have port ioInputs, output, W+depth+2 bits: the packed kernel-buffer IO control word.
REQ-014 SHALL have port address, output, A bits: the kernel-buffer row address.
REQ-015 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL pack ioInputs as follows: [W-1:0] data, [W+depth-1:W] bank select, [W+depth] write, [W+depth+1] IO select.
REQ-018 SHALL implement three states: IDLE, LOAD and DONE.
- IDLE->LOAD on start with numRows != 0.
- IDLE->DONE on start with numRows == 0.
- LOAD->DONE on acceptance of the last beat.
- DONE->IDLE unconditionally after 1 cycle.
REQ-019 SHALL drive inReady = 1 exactly when the state is LOAD; a beat is accepted when inValid && inReady.
REQ-020 SHALL keep a bank counter (depth bits) and a row counter (A bits), both cleared at start.
- Each accept increments the bank counter.
- When bank == D-1 the bank counter wraps to 0 and the row counter increments.
REQ-021 SHALL treat the last beat as the accept with bank == D-1 and row == numRows-1.
REQ-022 SHALL register all outputs; an accept in cycle N produces, in cycle N+1:
- write = 1;
- data = the accepted inData;
- bank = the bank counter value at the accept;
- address = (baseAddr + row) mod 2^A, so wrap-around is permitted.
REQ-023 SHALL drive write = 0 in every cycle not following an accept; data, bank and address then hold their previous values.
REQ-024 SHALL drive IO select = 1 in every cycle the state is LOAD or DONE, and 0 in IDLE.
REQ-025 SHALL assert done = 1 only in the DONE cycle.
- That cycle presents the final write when numRows != 0.
- With numRows == 0, the DONE cycle has write = 0 and no write occurs at all.
REQ-026 SHALL ignore start while the state is LOAD or DONE; the captured baseAddr and numRows remain unchanged.
REQ-027 SHALL issue exactly numRows*D writes per load, in strict order: bank 0..D-1 within each row, rows ascending.

Reset
REQ-028 SHALL, with RST high at a clock edge:
- force IDLE;
- clear both counters;
- drive ioInputs = 0, address = 0, inReady = 0, busy = 0 and done = 0 from the next cycle.
REQ-029 SHALL give RST priority over start and over any accept in the same cycle.
REQ-030 SHALL NOT undo buffer writes completed before a mid-load reset; a subsequent start restarts at bank 0, row 0.

Verification (depth=2, D=4, W=16, A=7)
REQ-031 SHALL cover reset: RST for 2 cycles -> ioInputs=0, address=0, inReady=0, busy=0, done=0.
REQ-032 SHALL cover a full load: start, baseAddr=5, numRows=2, inValid held high with data 1..8 -> eight consecutive write cycles:
- banks 0,1,2,3 at address 5 carrying data 1..4;
- banks 0,1,2,3 at address 6 carrying data 5..8;
- done=1 in the cycle of the write carrying data 8, then busy=0.
REQ-033 SHALL cover a stalled stream: inValid toggling 1,0,1,0 -> write=1 only in cycles after an accept, bank order 0,1,2,3 preserved, and address held steady during the gaps.
REQ-034 SHALL cover empty and wrapped loads:
- numRows=0 -> DONE the next cycle with done=1, write=0 and no writes;
- baseAddr=127, numRows=2 -> row 0 writes at address 127, row 1 writes at address 0.
REQ-035 SHALL cover reset mid-load and start while busy:
- RST after 3 accepts -> IDLE and all outputs 0 the next cycle; a new start writes bank 0 first;
- start pulsed during LOAD -> no effect on the address or the write count.
